// File: rtl/spi_pkg.sv
// Shared state encoding, SPI mode constants and a clog2 helper for the SPI master.
package spi_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LEAD = 2'd1,
    XFER = 2'd2,
    LAG  = 2'd3
  } spi_state_e;

  // Modes encoded as {cpol, cpha}.
  localparam logic [1:0] SPI_MODE0 = 2'b00;
  localparam logic [1:0] SPI_MODE1 = 2'b01;
  localparam logic [1:0] SPI_MODE2 = 2'b10;
  localparam logic [1:0] SPI_MODE3 = 2'b11;

  function automatic int unsigned clog2(input int unsigned value);
    int unsigned res;
    res = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'(1) << i) < 64'(value)) res = i + 1;
    end
    return res;
  endfunction

endpackage

// File: rtl/spi_clk_div.sv
// Half-period prescaler: tick_c marks the last cycle of every clk_div-cycle window while run_i is high.
module spi_clk_div
  import spi_pkg::*;
#(
  parameter int unsigned clk_div = 4
) (
  input  logic clk,
  input  logic reset_n,
  input  logic run_i,
  output logic tick_c
);

  localparam int unsigned CNT_W = (clk_div > 1) ? clog2(clk_div) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(clk_div - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign tick_c = run_i && (cnt_q == CNT_MAX);

  always_comb begin
    cnt_d = cnt_q;
    if (!run_i || tick_c) cnt_d = '0;
    else                  cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) cnt_q <= '0;
    else          cnt_q <= cnt_d;
  end

endmodule

// File: rtl/spi_master.sv
// SPI master with runtime CPOL/CPHA, MSB-first, one word per enable request.
// Define SPI_MASTER_CONTINUOUS_EN to chain words under one ss_n assertion while enable stays high.
module spi_master
  import spi_pkg::*;
#(
  parameter int unsigned data_length = 16,
  parameter int unsigned clk_div     = 4
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   enable,
  input  logic                   cpol,
  input  logic                   cpha,
  input  logic [data_length-1:0] tx,
  output logic [data_length-1:0] rx,
  output logic                   done,
  output logic                   busy,
  output logic                   sclk,
  output logic                   ss_n,
  output logic                   mosi,
  input  logic                   miso
);

  localparam int unsigned EDGE_W = clog2(2 * data_length) + 1;
  localparam logic [EDGE_W-1:0] LAST_EDGE = EDGE_W'(2 * data_length - 1);

  spi_state_e             state_q, state_d;
  logic                   cpol_q, cpol_d, cpha_q, cpha_d;
  logic [data_length-1:0] shift_tx_q, shift_tx_d, shift_rx_q, shift_rx_d, rx_q, rx_d;
  logic [EDGE_W-1:0]      edge_q, edge_d;
  logic                   done_q, done_d, busy_q, busy_d;
  logic                   sclk_q, sclk_d, ss_n_q, ss_n_d, mosi_q, mosi_d;
  logic                   tick, leading, last_edge, sample;
  logic [data_length-1:0] rx_shifted;

  spi_clk_div #(.clk_div(clk_div)) u_clk_div (
    .clk    (clk),
    .reset_n(reset_n),
    .run_i  (state_q != IDLE),
    .tick_c (tick)
  );

  always_comb begin
    state_d    = state_q;
    cpol_d     = cpol_q;
    cpha_d     = cpha_q;
    shift_tx_d = shift_tx_q;
    shift_rx_d = shift_rx_q;
    edge_d     = edge_q;
    rx_d       = rx_q;
    done_d     = 1'b0;
    busy_d     = busy_q;
    sclk_d     = sclk_q;
    ss_n_d     = ss_n_q;
    mosi_d     = mosi_q;
    // Even edge counts are leading edges (sclk leaving its idle level).
    leading    = ~edge_q[0];
    last_edge  = (edge_q == LAST_EDGE);
    sample     = leading ^ cpha_q;
    rx_shifted = {shift_rx_q[data_length-2:0], miso};

    case (state_q)
      IDLE: begin
        if (enable) begin
          shift_tx_d = tx;
          cpol_d     = cpol;
          cpha_d     = cpha;
          sclk_d     = cpol;
          busy_d     = 1'b1;
          ss_n_d     = 1'b0;
          mosi_d     = tx[data_length-1];
          edge_d     = '0;
          state_d    = LEAD;
        end
      end
      LEAD: begin
        if (tick) state_d = XFER;
      end
      XFER: begin
        if (tick) begin
          sclk_d = ~sclk_q;
          edge_d = edge_q + EDGE_W'(1);
          if (sample) shift_rx_d = rx_shifted;
          // MSB is already on mosi, so cpha=1 skips its first leading edge and cpha=0 its last trailing edge.
          if ((cpha_q && leading && (edge_q != '0)) || (!cpha_q && !leading && !last_edge)) begin
            shift_tx_d = shift_tx_q << 1;
            mosi_d     = shift_tx_q[data_length-2];
          end
          if (last_edge) begin
`ifdef SPI_MASTER_CONTINUOUS_EN
            if (enable) begin
              rx_d       = sample ? rx_shifted : shift_rx_q;
              done_d     = 1'b1;
              shift_tx_d = tx;
              cpha_d     = cpha;
              mosi_d     = tx[data_length-1];
              edge_d     = '0;
              state_d    = LEAD;
            end else begin
              state_d = LAG;
            end
`else
            state_d = LAG;
`endif
          end
        end
      end
      LAG: begin
        if (tick) begin
          ss_n_d  = 1'b1;
          rx_d    = shift_rx_q;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          mosi_d  = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      cpol_q     <= 1'b0;
      cpha_q     <= 1'b0;
      shift_tx_q <= '0;
      shift_rx_q <= '0;
      edge_q     <= '0;
      rx_q       <= '0;
      done_q     <= 1'b0;
      busy_q     <= 1'b0;
      sclk_q     <= 1'b0;
      ss_n_q     <= 1'b1;
      mosi_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cpol_q     <= cpol_d;
      cpha_q     <= cpha_d;
      shift_tx_q <= shift_tx_d;
      shift_rx_q <= shift_rx_d;
      edge_q     <= edge_d;
      rx_q       <= rx_d;
      done_q     <= done_d;
      busy_q     <= busy_d;
      sclk_q     <= sclk_d;
      ss_n_q     <= ss_n_d;
      mosi_q     <= mosi_d;
    end
  end

  assign rx   = rx_q;
  assign done = done_q;
  assign busy = busy_q;
  assign sclk = sclk_q;
  assign ss_n = ss_n_q;
  assign mosi = mosi_q;

endmodule

// File: tb/tb_spi_master.sv
// Directed bench for spi_master: vector table over modes plus reset, ignored-request and held-enable sequences.
module tb_spi_master;
  import spi_pkg::*;

  localparam int unsigned DL  = 16;
  localparam int unsigned CD  = 2;
  localparam int          LAT = (2 * DL + 2) * CD + 1;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          enable = 1'b0;
  logic          cpol = 1'b0;
  logic          cpha = 1'b0;
  logic [DL-1:0] tx = '0;
  logic [DL-1:0] rx;
  logic          done, busy, sclk, ss_n, mosi, miso;

  logic          loop_sel = 1'b1;
  logic [DL-1:0] slv_tx_word = '0;
  logic [DL-1:0] slv_shreg = '0;
  logic [DL-1:0] slv_rx = '0;
  logic          slv_miso = 1'b0;
  logic          slv_cpol = 1'b0;
  logic          slv_cpha = 1'b0;
  logic          slv_pss = 1'b1;
  logic          slv_psclk = 1'b0;
  int            slv_n = 0;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [1:0]    mode;
    logic          loop;
    logic [DL-1:0] tx;
    logic [DL-1:0] stx;
    logic [DL-1:0] exp_rx;
    logic          exp_idle;
  } vec_t;

  vec_t vecs [6];

  spi_master #(.data_length(DL), .clk_div(CD)) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .enable (enable),
    .cpol   (cpol),
    .cpha   (cpha),
    .tx     (tx),
    .rx     (rx),
    .done   (done),
    .busy   (busy),
    .sclk   (sclk),
    .ss_n   (ss_n),
    .mosi   (mosi),
    .miso   (miso)
  );

  always #5 clk = ~clk;

  assign miso = loop_sel ? mosi : slv_miso;

  // Behavioural slave: loads on ss_n fall, samples on sample edges, shifts on change edges once a bit is in.
  always @(sclk or ss_n) begin
    if (ss_n != slv_pss) begin
      if (!ss_n) begin
        slv_shreg = slv_tx_word;
        slv_miso  = slv_tx_word[DL-1];
        slv_rx    = '0;
        slv_n     = 0;
      end
    end else if (!ss_n && (sclk != slv_psclk)) begin
      if (sclk == ~(slv_cpol ^ slv_cpha)) begin
        slv_rx = {slv_rx[DL-2:0], mosi};
        slv_n++;
      end else if (slv_n > 0 && slv_n < DL) begin
        slv_shreg = slv_shreg << 1;
        slv_miso  = slv_shreg[DL-1];
      end
    end
    slv_pss   = ss_n;
    slv_psclk = sclk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic run_word(input vec_t v, input bit disturb, input string tag);
    int   n, rises, busy_low, mosi_bad, ss_low;
    logic p_sclk, p_mosi, p_ss, chg;
    chg = v.mode[1] ^ v.mode[0];
    @(negedge clk);
    cpol = v.mode[1]; cpha = v.mode[0]; tx = v.tx;
    slv_tx_word = v.stx; slv_cpol = v.mode[1]; slv_cpha = v.mode[0];
    loop_sel = v.loop;
    enable = 1'b1;
    n = 0; rises = 0; busy_low = 0; mosi_bad = 0;
    p_sclk = sclk; p_mosi = mosi; p_ss = ss_n;
    while (n < 400) begin
      @(posedge clk); #1;
      n++;
      if (n == 1) enable = 1'b0;
      if (disturb && n == 20) begin
        enable = 1'b1; tx = '1; cpol = ~v.mode[1]; cpha = ~v.mode[0];
      end
      if (disturb && n == 21) enable = 1'b0;
      if (!ss_n && !p_ss && !p_sclk && sclk) rises++;
      if (!ss_n && !p_ss && (mosi != p_mosi) && !((p_sclk != sclk) && (sclk == chg))) mosi_bad++;
      if (done) break;
      if (!busy) busy_low++;
      p_sclk = sclk; p_mosi = mosi; p_ss = ss_n;
    end
    check($sformatf("%s_latency", tag), 32'(n), 32'(LAT));
    check($sformatf("%s_rx", tag), 32'(rx), 32'(v.exp_rx));
    check($sformatf("%s_slave_rx", tag), 32'(slv_rx), 32'(v.tx));
    check($sformatf("%s_sclk_rises", tag), 32'(rises), 32'(DL));
    check($sformatf("%s_mosi_edge", tag), 32'(mosi_bad), 32'(0));
    check($sformatf("%s_busy_gap", tag), 32'(busy_low), 32'(0));
    check($sformatf("%s_busy_at_done", tag), 32'(busy), 32'(0));
    @(posedge clk); #1;
    check($sformatf("%s_done_pulse", tag), 32'(done), 32'(0));
    check($sformatf("%s_sclk_idle", tag), 32'(sclk), 32'(v.exp_idle));
    if (disturb) begin
      ss_low = 0;
      for (int i = 0; i < 60; i++) begin
        @(posedge clk); #1;
        if (!ss_n || busy) ss_low++;
      end
      check($sformatf("%s_no_second", tag), 32'(ss_low), 32'(0));
      check($sformatf("%s_rx_kept", tag), 32'(rx), 32'(v.exp_rx));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    int   edges, cyc, starts, dones, ss_hi, rises, exp_ss_hi;
    logic p, pb, ps, psclk;

    vecs[0] = '{SPI_MODE0, 1'b1, 16'hA5C3, 16'h0000, 16'hA5C3, 1'b0};
    vecs[1] = '{SPI_MODE3, 1'b0, 16'h8001, 16'h3C5A, 16'h3C5A, 1'b1};
    vecs[2] = '{SPI_MODE0, 1'b0, 16'hBEEF, 16'h1234, 16'h1234, 1'b0};
    vecs[3] = '{SPI_MODE1, 1'b0, 16'hBEEF, 16'h1234, 16'h1234, 1'b0};
    vecs[4] = '{SPI_MODE2, 1'b0, 16'hBEEF, 16'h1234, 16'h1234, 1'b1};
    vecs[5] = '{SPI_MODE3, 1'b0, 16'hBEEF, 16'h1234, 16'h1234, 1'b1};

    #12;
    check("reset_rx", 32'(rx), 32'(0));
    check("reset_done", 32'(done), 32'(0));
    check("reset_busy", 32'(busy), 32'(0));
    check("reset_sclk", 32'(sclk), 32'(0));
    check("reset_ss_n", 32'(ss_n), 32'(1));
    check("reset_mosi", 32'(mosi), 32'(0));
    @(negedge clk); reset_n = 1'b1;
    repeat (2) @(negedge clk);

    // Reset asserted right after the 7th sclk edge of a transfer.
    cpol = 1'b0; cpha = 1'b0; tx = 16'hA5C3; loop_sel = 1'b1; enable = 1'b1;
    @(posedge clk); #1 enable = 1'b0;
    edges = 0; cyc = 0; p = sclk;
    while (edges < 7 && cyc < 200) begin
      @(posedge clk); #1;
      cyc++;
      if (sclk != p) edges++;
      p = sclk;
    end
    check("rst_edge7_reached", 32'(edges), 32'(7));
    reset_n = 1'b0;
    #1;
    check("rst_ss_n", 32'(ss_n), 32'(1));
    check("rst_sclk", 32'(sclk), 32'(0));
    check("rst_busy", 32'(busy), 32'(0));
    check("rst_rx", 32'(rx), 32'(0));
    check("rst_done", 32'(done), 32'(0));
    @(negedge clk); reset_n = 1'b1;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 6; i++) run_word(vecs[i], 1'b0, $sformatf("v%0d", i));

    run_word(vecs[0], 1'b1, "disturb");

    // Enable held high across three words.
    @(negedge clk);
    cpol = 1'b0; cpha = 1'b0; loop_sel = 1'b1; tx = 16'h0001; enable = 1'b1;
    starts = 0; dones = 0; ss_hi = 0; rises = 0; cyc = 0;
    pb = busy; ps = ss_n; psclk = sclk;
    while (dones < 3 && cyc < 1000) begin
      @(posedge clk); #1;
      cyc++;
      if ((busy && !pb) || (done && busy)) begin
        starts++;
        tx = DL'(starts + 1);
        if (starts == 3) enable = 1'b0;
      end
      if (done) begin
        check($sformatf("held_rx%0d", dones), 32'(rx), 32'(dones + 1));
        dones++;
      end
      if (starts > 0 && dones < 3 && ss_n) ss_hi++;
      if (!ss_n && !ps && !psclk && sclk) rises++;
      pb = busy; ps = ss_n; psclk = sclk;
    end
`ifdef SPI_MASTER_CONTINUOUS_EN
    exp_ss_hi = 0;
`else
    exp_ss_hi = 2;
`endif
    check("held_dones", 32'(dones), 32'(3));
    check("held_ss_high_cycles", 32'(ss_hi), 32'(exp_ss_hi));
    check("held_sclk_rises", 32'(rises), 32'(3 * DL));
    repeat (10) @(posedge clk);
    #1;
    check("held_idle_busy", 32'(busy), 32'(0));
    check("held_idle_ss_n", 32'(ss_n), 32'(1));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
